// File: rtl/oscan1_host_driver.sv
// Host-side cJTAG OScan1 driver: escape/activation sequencing and 3-phase scan packets.
// One command in flight at a time; TCKC half-period is CLK_DIV system clocks.
module oscan1_host_driver #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_tms,
  input  logic       cmd_tdi,
  output logic       rsp_valid,
  output logic       rsp_tdo,
  output logic       rsp_err,
  output logic       tckc,
  output logic       tmsc_out,
  output logic       tmsc_oen,
  input  logic       tmsc_in,
  output logic       online,
  output logic       busy
);

  // state     | meaning
  // IDLE      | ready for a command, TMSC released
  // ESC       | TCKC held high while TMSC toggles N times
  // OAC       | 12 activation bit-cycles (CP, EC, OAC)
  // SCAN_NTDI | bit-cycle 1: drive inverted TDI (or flag offline)
  // SCAN_TMS  | bit-cycle 2: drive TMS
  // SCAN_TDO  | bit-cycle 3: TMSC released, sample TDO
  // RESP      | one-cycle completion pulse, online update

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("CLK_DIV out of range 2..255");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ESC, S_OAC, S_SCAN_NTDI, S_SCAN_TMS, S_SCAN_TDO, S_RESP
  } state_t;

  localparam logic [1:0]  OP_SCAN  = 2'b00;
  localparam logic [1:0]  OP_ACT   = 2'b01;
  localparam logic [1:0]  OP_RESET = 2'b10;
  localparam logic [7:0]  HP_MAX   = 8'(CLK_DIV - 1);
  // Bit-cycle values LSB first: 0,0,1,1,0,0,0,1,0,0,0,0
  localparam logic [15:0] OAC_SEQ  = 16'h008C;

  state_t     state_q, state_d;
  logic [7:0] hp_q, hp_d;
  logic [4:0] half_q, half_d;
  logic [1:0] op_q, op_d;
  logic       tms_q, tms_d;
  logic       tdi_q, tdi_d;
  logic       tdo_q, tdo_d;
  logic       err_q, err_d;
  logic       online_q, online_d;

  logic       hp_end;
  logic       timed;
  logic       phase_done;
  logic [4:0] last_half;
  logic [4:0] esc_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hp_q     <= '0;
      half_q   <= '0;
      op_q     <= OP_SCAN;
      tms_q    <= 1'b0;
      tdi_q    <= 1'b0;
      tdo_q    <= 1'b0;
      err_q    <= 1'b0;
      online_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      half_q   <= half_d;
      op_q     <= op_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      tdo_q    <= tdo_d;
      err_q    <= err_d;
      online_q <= online_d;
    end
  end

  // Last half-period index of the escape: N toggles plus a hold on each side.
  always_comb begin
    esc_last = 5'd7;
    case (op_q)
      OP_RESET: esc_last = 5'd9;
      2'b11:    esc_last = 5'd5;
      default:  esc_last = 5'd7;
    endcase
  end

  always_comb begin
    timed     = 1'b1;
    last_half = 5'd1;
    case (state_q)
      S_ESC:       last_half = esc_last;
      S_OAC:       last_half = 5'd23;
      S_SCAN_NTDI,
      S_SCAN_TMS,
      S_SCAN_TDO:  last_half = 5'd1;
      default:     timed = 1'b0;
    endcase
  end

  assign hp_end     = (hp_q == HP_MAX);
  assign phase_done = timed && hp_end && (half_q == last_half);

  always_comb begin
    state_d   = state_q;
    hp_d      = '0;
    half_d    = '0;
    op_d      = op_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    tdo_d     = tdo_q;
    err_d     = err_q;
    online_d  = online_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_tdo   = 1'b0;
    rsp_err   = 1'b0;
    tckc      = 1'b0;
    tmsc_out  = 1'b1;
    tmsc_oen  = 1'b0;

    if (timed) begin
      hp_d   = hp_end ? 8'd0 : hp_q + 8'd1;
      half_d = phase_done ? 5'd0 : (hp_end ? half_q + 5'd1 : half_q);
    end

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          tms_d   = cmd_tms;
          tdi_d   = cmd_tdi;
          tdo_d   = 1'b0;
          err_d   = 1'b0;
          state_d = (cmd_op == OP_SCAN) ? S_SCAN_NTDI : S_ESC;
        end
      end
      S_ESC: begin
        tckc     = 1'b1;
        tmsc_oen = 1'b1;
        tmsc_out = (half_q == esc_last) ? 1'b1 : ~half_q[0];
        if (phase_done) state_d = (op_q == OP_ACT) ? S_OAC : S_RESP;
      end
      S_OAC: begin
        tckc     = half_q[0];
        tmsc_oen = 1'b1;
        tmsc_out = OAC_SEQ[half_q[4:1]];
        if (phase_done) state_d = S_RESP;
      end
      S_SCAN_NTDI: begin
        if (!online_q) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tckc     = half_q[0];
          tmsc_oen = 1'b1;
          tmsc_out = ~tdi_q;
          if (phase_done) state_d = S_SCAN_TMS;
        end
      end
      S_SCAN_TMS: begin
        tckc     = half_q[0];
        tmsc_oen = 1'b1;
        tmsc_out = tms_q;
        if (phase_done) state_d = S_SCAN_TDO;
      end
      S_SCAN_TDO: begin
        tckc = half_q[0];
        if (half_q[0] && hp_end) tdo_d = tmsc_in;
        if (phase_done) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_tdo   = tdo_q;
        rsp_err   = err_q;
        if (op_q == OP_ACT) online_d = 1'b1;
        else if (op_q != OP_SCAN) online_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign online = online_q;
  assign busy   = ~cmd_ready;

endmodule

// File: tb/tb_oscan1_host_driver.sv
// Directed bench for oscan1_host_driver at CLK_DIV=2: vector table plus
// back-to-back and mid-command reset sequences, with a simple TMSC pad/target model.
module tb_oscan1_host_driver;

  localparam int D = 2;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_tms;
  logic       cmd_tdi;
  logic       rsp_valid;
  logic       rsp_tdo;
  logic       rsp_err;
  logic       tckc;
  logic       tmsc_out;
  logic       tmsc_oen;
  logic       tmsc_in;
  logic       online;
  logic       busy;
  logic       tdo_model;
  logic       tmsc_line;

  int tests = 0;
  int fails = 0;

  oscan1_host_driver #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
    .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo), .rsp_err(rsp_err),
    .tckc(tckc), .tmsc_out(tmsc_out), .tmsc_oen(tmsc_oen), .tmsc_in(tmsc_in),
    .online(online), .busy(busy)
  );

  // Pad: host drives when enabled, otherwise the target model drives TDO.
  assign tmsc_line = tmsc_oen ? tmsc_out : tdo_model;
  assign tmsc_in   = tmsc_line;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic        tms;
    logic        tdi;
    logic        tdo_m;
    int          lat;
    logic        exp_tdo;
    logic        exp_err;
    logic        exp_online;
    int          rises;
    logic [15:0] bits;
    int          toggles;
    int          high;
    int          oenlow;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input string nm);
    int          cyc;
    int          rises;
    int          toggles;
    int          high;
    int          oenlow;
    int          ready_bad;
    logic [15:0] bits;
    logic        prev_tckc;
    logic        prev_out;
    logic        got_tdo;
    logic        got_err;
    rises = 0; toggles = 0; high = 0; oenlow = 0; ready_bad = 0; bits = '0;
    got_tdo = 1'bx; got_err = 1'bx;
    tdo_model = v.tdo_m;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_tms = v.tms; cmd_tdi = v.tdi;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1; prev_tckc = 1'b0; prev_out = 1'b1;
    while (!rsp_valid && cyc < 200) begin
      if (tckc && !prev_tckc) begin
        if (rises < 16) bits[rises] = tmsc_line;
        rises++;
      end
      if (tckc && prev_tckc && (tmsc_out != prev_out)) toggles++;
      if (tckc) high++;
      if (!tmsc_oen) oenlow++;
      if (cmd_ready || !busy) ready_bad++;
      prev_tckc = tckc; prev_out = tmsc_out;
      @(posedge clk); #1;
      cyc++;
    end
    if (rsp_valid) begin
      got_tdo = rsp_tdo; got_err = rsp_err;
    end
    chk({nm, " latency"}, cyc, v.lat);
    chk({nm, " rsp_tdo"}, got_tdo, v.exp_tdo);
    chk({nm, " rsp_err"}, got_err, v.exp_err);
    @(posedge clk); #1;
    chk({nm, " rsp_valid width"}, rsp_valid, 1'b0);
    chk({nm, " online"}, online, v.exp_online);
    chk({nm, " ready after"}, cmd_ready, 1'b1);
    chk({nm, " ready while busy"}, ready_bad, 0);
    chk({nm, " tckc rises"}, rises, v.rises);
    chk({nm, " tmsc at rises"}, bits, v.bits);
    chk({nm, " toggles while high"}, toggles, v.toggles);
    chk({nm, " tckc high cycles"}, high, v.high);
    chk({nm, " oen low cycles"}, oenlow, v.oenlow);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " cmd_ready"}, cmd_ready, 1'b1);
    chk({nm, " busy"}, busy, 1'b0);
    chk({nm, " rsp_valid"}, rsp_valid, 1'b0);
    chk({nm, " rsp_tdo"}, rsp_tdo, 1'b0);
    chk({nm, " rsp_err"}, rsp_err, 1'b0);
    chk({nm, " tckc"}, tckc, 1'b0);
    chk({nm, " tmsc_out"}, tmsc_out, 1'b1);
    chk({nm, " tmsc_oen"}, tmsc_oen, 1'b0);
    chk({nm, " online"}, online, 1'b0);
  endtask

  initial begin
    int acc;
    int pulses;
    int tdo_ones;
    int bad;
    int after;

    //        op     tms   tdi   tdo   lat tdo   err   onl   rises bits      tog high oenlow
    vecs[0] = '{2'b00, 1'b0, 1'b1, 1'b1, 2,  1'b0, 1'b1, 1'b0, 0,  16'h0000, 0, 0,  1};
    vecs[1] = '{2'b01, 1'b0, 1'b0, 1'b0, 65, 1'b0, 1'b0, 1'b1, 13, 16'h0119, 6, 40, 0};
    vecs[2] = '{2'b00, 1'b0, 1'b1, 1'b1, 13, 1'b1, 1'b0, 1'b1, 3,  16'h0004, 0, 6,  4};
    vecs[3] = '{2'b00, 1'b0, 1'b1, 1'b0, 13, 1'b0, 1'b0, 1'b1, 3,  16'h0000, 0, 6,  4};
    vecs[4] = '{2'b00, 1'b1, 1'b0, 1'b1, 13, 1'b1, 1'b0, 1'b1, 3,  16'h0007, 0, 6,  4};
    vecs[5] = '{2'b10, 1'b0, 1'b0, 1'b0, 21, 1'b0, 1'b0, 1'b0, 1,  16'h0001, 8, 20, 0};
    vecs[6] = '{2'b01, 1'b0, 1'b0, 1'b0, 65, 1'b0, 1'b0, 1'b1, 13, 16'h0119, 6, 40, 0};
    vecs[7] = '{2'b01, 1'b0, 1'b0, 1'b0, 65, 1'b0, 1'b0, 1'b1, 13, 16'h0119, 6, 40, 0};
    vecs[8] = '{2'b11, 1'b0, 1'b0, 1'b0, 13, 1'b0, 1'b0, 1'b0, 1,  16'h0001, 4, 12, 0};
    vecs[9] = '{2'b00, 1'b1, 1'b1, 1'b1, 2,  1'b0, 1'b1, 1'b0, 0,  16'h0000, 0, 0,  1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_tms = 1'b0; cmd_tdi = 1'b0;
    tdo_model = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("idle");

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Three back-to-back scans with cmd_valid held high.
    run_cmd(vecs[1], "act_b2b");
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_tms = 1'b0; cmd_tdi = 1'b0; tdo_model = 1'b1;
    acc = 0; pulses = 0; tdo_ones = 0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc++;
      @(posedge clk); #1;
      if (acc == 3) cmd_valid = 1'b0;
      if (rsp_valid) begin
        pulses++;
        if (rsp_tdo) tdo_ones++;
      end
      if (busy !== ~cmd_ready) bad++;
    end
    chk("b2b accepts", acc, 3);
    chk("b2b rsp pulses", pulses, 3);
    chk("b2b tdo ones", tdo_ones, 3);
    chk("b2b busy vs ready", bad, 0);

    // Reset asserted partway through the second of three scans.
    run_cmd(vecs[1], "act_rst");
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_tms = 1'b1; cmd_tdi = 1'b1; tdo_model = 1'b0;
    acc = 0; pulses = 0; after = 0;
    for (int c = 0; c < 60 && after < 3; c++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc++;
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
      if (acc == 2) after++;
    end
    chk("rst mid accepts", acc, 2);
    chk("rst mid tckc high before", tckc, 1'b1);
    chk("rst mid online before", online, 1'b1);
    #2;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk_reset_vals("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    chk("rst mid rsp pulses", pulses, 1);
    chk("rst mid online after", online, 1'b0);
    run_cmd(vecs[0], "scan_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
